// File: rtl/hyst_cmp_pkg.sv
// Shared types and defaults for the multi-channel hysteresis comparator.
// Holds the channel state encoding and the dwell counter sizing helper.
package hyst_cmp_pkg;

  localparam int W_DEF     = 8;
  localparam int N_CH_DEF  = 4;
  localparam int DWELL_DEF = 4;

  typedef enum logic [1:0] {
    B_GE   = 2'd0,
    ARM_UP = 2'd1,
    A_GT   = 2'd2,
    ARM_DN = 2'd3
  } state_t;

  // Counter must hold values 0..dwell.
  function automatic int cnt_w(input int dwell);
    return $clog2(dwell + 32'sd1);
  endfunction

endpackage

// File: rtl/hyst_cmp_if.sv
// Bus between the sensor front-end (master) and the comparator array (slave).
interface hyst_cmp_if #(
  parameter int W    = 8,
  parameter int N_CH = 4
);
  logic                en;
  logic [W-1:0]        th;
  logic [N_CH*W-1:0]   ts_a;
  logic [N_CH*W-1:0]   ts_b;
  logic [N_CH-1:0]     out;
  logic [N_CH-1:0]     chg;
  logic                any_out;

  modport master (output en, th, ts_a, ts_b, input out, chg, any_out);
  modport slave  (input en, th, ts_a, ts_b, output out, chg, any_out);
endinterface

// File: rtl/hyst_cmp_ch.sv
// One comparator channel: dwell-qualified hysteresis FSM with registered
// regime output and a one-cycle change pulse.
module hyst_cmp_ch
  import hyst_cmp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] th,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out,
  output logic         chg,
  output logic         out_nxt
);

  localparam int            CW       = cnt_w(DWELL);
  localparam logic [CW-1:0] DWELL_C  = CW'(DWELL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam bit            ONE_SHOT = (DWELL == 32'sd1);

  logic          valid_s, up_s, dn_s;
  logic [W:0]    a_sum_s, b_sum_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  state_t        state_r, state_nxt_s;
  logic          out_r, chg_r, out_nxt_s;

  // Sums are one bit wider than the readings so a large th never wraps.
  assign valid_s   = (a != {W{1'b0}}) && (b != {W{1'b0}});
  assign a_sum_s   = {1'b0, a} + {1'b0, th};
  assign b_sum_s   = {1'b0, b} + {1'b0, th};
  assign up_s      = valid_s && ({1'b0, a} > b_sum_s);
  assign dn_s      = valid_s && ({1'b0, b} > a_sum_s);
  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Next-state and dwell counter; everything holds while en is low.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (en) begin
      case (state_r)
        B_GE: begin
          if (up_s) begin
            state_nxt_s = ONE_SHOT ? A_GT : ARM_UP;
            cnt_nxt_s   = ONE_SHOT ? CNT_ZERO : CNT_ONE;
          end else begin
            state_nxt_s = B_GE;
          end
        end
        ARM_UP: begin
          if (up_s && (cnt_inc_s == DWELL_C)) begin
            state_nxt_s = A_GT;
            cnt_nxt_s   = CNT_ZERO;
          end else if (up_s) begin
            cnt_nxt_s   = cnt_inc_s;
          end else begin
            state_nxt_s = B_GE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        A_GT: begin
          if (dn_s) begin
            state_nxt_s = ONE_SHOT ? B_GE : ARM_DN;
            cnt_nxt_s   = ONE_SHOT ? CNT_ZERO : CNT_ONE;
          end else begin
            state_nxt_s = A_GT;
          end
        end
        ARM_DN: begin
          if (dn_s && (cnt_inc_s == DWELL_C)) begin
            state_nxt_s = B_GE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (dn_s) begin
            cnt_nxt_s   = cnt_inc_s;
          end else begin
            state_nxt_s = A_GT;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        default: begin
          state_nxt_s = B_GE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // ARM_DN still reports the hot regime so arming never glitches out.
  assign out_nxt_s = (state_nxt_s == A_GT) || (state_nxt_s == ARM_DN);

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= B_GE;
      cnt_r   <= CNT_ZERO;
      out_r   <= 1'b0;
      chg_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= out_nxt_s;
      chg_r   <= out_nxt_s ^ out_r;
    end
  end

  assign out     = out_r;
  assign chg     = chg_r;
  assign out_nxt = out_nxt_s;

endmodule

// File: rtl/hyst_cmp_array.sv
// N_CH independent hysteresis comparator channels plus a registered
// aggregate flag aligned with the per-channel outputs.
module hyst_cmp_array
  import hyst_cmp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N_CH  = N_CH_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input logic       clk,
  input logic       rst,
  hyst_cmp_if.slave bus
);

  logic [N_CH-1:0] out_s, chg_s, out_nxt_s;
  logic            any_r;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hyst_cmp_ch #(
      .W     (W),
      .DWELL (DWELL)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .th      (bus.th),
      .a       (bus.ts_a[i*W +: W]),
      .b       (bus.ts_b[i*W +: W]),
      .out     (out_s[i]),
      .chg     (chg_s[i]),
      .out_nxt (out_nxt_s[i])
    );
  end

  // Built from next-state so it lands in the same cycle as out.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_r <= 1'b0;
    end else begin
      any_r <= |out_nxt_s;
    end
  end

  assign bus.out     = out_s;
  assign bus.chg     = chg_s;
  assign bus.any_out = any_r;

endmodule

// File: tb/tb_hyst_cmp_array.sv
// Randomised and directed bench for hyst_cmp_array against a run-length
// reference model of the dwell-qualified hysteresis rules.
module tb_hyst_cmp_array;
  localparam int W     = 8;
  localparam int N_CH  = 4;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyst_cmp_if #(.W(W), .N_CH(N_CH)) bus ();

  hyst_cmp_array #(.W(W), .N_CH(N_CH), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] a_v [N_CH];
  logic [W-1:0] b_v [N_CH];
  bit           m_hi  [N_CH];
  int           m_run [N_CH];
  bit           m_chg [N_CH];
  bit           m_any;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_ch(input int i, input int a, input int b);
    a_v[i] = W'(a);
    b_v[i] = W'(b);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N_CH; i++) set_ch(i, 0, 0);
  endtask

  // Model: a channel flips its regime after DWELL consecutive enabled
  // cycles of the condition that opposes its current regime.
  task automatic model_edge();
    int a, b, t;
    bit valid, up, dn, cond;
    t = int'(bus.th);
    m_any = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_chg[i] = 1'b0;
      if (rst) begin
        m_hi[i]  = 1'b0;
        m_run[i] = 0;
      end else if (bus.en) begin
        a = int'(a_v[i]);
        b = int'(b_v[i]);
        valid = (a != 0) && (b != 0);
        up = valid && (a > b + t);
        dn = valid && (b > a + t);
        cond = m_hi[i] ? dn : up;
        if (cond) begin
          m_run[i]++;
          if (m_run[i] == DWELL) begin
            m_hi[i]  = !m_hi[i];
            m_run[i] = 0;
            m_chg[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_any = m_any | m_hi[i];
    end
  endtask

  task automatic step();
    logic [N_CH-1:0] e_out, e_chg;
    for (int i = 0; i < N_CH; i++) begin
      bus.ts_a[i*W +: W] = a_v[i];
      bus.ts_b[i*W +: W] = b_v[i];
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N_CH; i++) begin
      e_out[i] = m_hi[i];
      e_chg[i] = m_chg[i];
    end
    chk("model_out", 32'(bus.out), 32'(e_out));
    chk("model_chg", 32'(bus.chg), 32'(e_chg));
    chk("model_any", 32'(bus.any_out), 32'(m_any));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.th = 8'd10;
    bus.ts_a = '0;
    bus.ts_b = '0;
    clear_all();

    // Reset held two cycles with a qualifying channel 0.
    set_ch(0, 50, 30);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_out", 32'(bus.out), 32'd0);
      chk("rst_chg", 32'(bus.chg), 32'd0);
      chk("rst_any", 32'(bus.any_out), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rise_early", 32'(bus.out), 32'd0);
    end
    step();
    chk("rise_out", 32'(bus.out), 32'h1);
    chk("rise_chg", 32'(bus.chg), 32'h1);
    chk("rise_any", 32'(bus.any_out), 32'd1);
    step();
    chk("rise_chg_once", 32'(bus.chg), 32'd0);

    // Strict boundary, wrap-free sums.
    do_reset();
    set_ch(0, 0, 0);
    set_ch(1, 40, 30);
    set_ch(2, 5, 250);
    set_ch(3, 250, 5);
    for (int k = 0; k < 10; k++) step();
    chk("boundary_out", 32'(bus.out), 32'h8);

    // Glitch rejection.
    do_reset();
    clear_all();
    set_ch(0, 50, 30);
    for (int k = 0; k < 3; k++) step();
    set_ch(0, 35, 30);
    step();
    chk("glitch_hold", 32'(bus.out), 32'd0);
    set_ch(0, 50, 30);
    for (int k = 0; k < 3; k++) step();
    chk("glitch_early", 32'(bus.out), 32'd0);
    step();
    chk("glitch_rise", 32'(bus.out), 32'h1);

    // Invalid reading holds the hot regime; then a real fall.
    set_ch(0, 50, 0);
    for (int k = 0; k < 10; k++) step();
    chk("invalid_hold", 32'(bus.out), 32'h1);
    set_ch(0, 20, 40);
    for (int k = 0; k < 3; k++) step();
    chk("fall_early", 32'(bus.out), 32'h1);
    step();
    chk("fall_out", 32'(bus.out), 32'd0);
    chk("fall_chg", 32'(bus.chg), 32'h1);
    set_ch(0, 50, 30);
    for (int k = 0; k < 4; k++) step();
    set_ch(0, 20, 30);
    for (int k = 0; k < 10; k++) step();
    chk("fall_boundary", 32'(bus.out), 32'h1);

    // Freeze mid-arming, then resume from the frozen count.
    do_reset();
    set_ch(0, 50, 30);
    step();
    step();
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("freeze_out", 32'(bus.out), 32'd0);
    bus.en = 1'b1;
    step();
    chk("resume_early", 32'(bus.out), 32'd0);
    step();
    chk("resume_rise", 32'(bus.out), 32'h1);

    // Reset at cnt=3 aborts arming.
    do_reset();
    for (int k = 0; k < 3; k++) step();
    do_reset();
    for (int k = 0; k < 3; k++) step();
    chk("midrst_early", 32'(bus.out), 32'd0);
    step();
    chk("midrst_rise", 32'(bus.out), 32'h1);

    // Randomised: sticky readings so dwell runs actually complete.
    for (int k = 0; k < 3000; k++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 19) == 0) bus.th = W'($urandom_range(0, 40));
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          a_v[i] = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 255));
          b_v[i] = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 255));
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyst_cmp_array.md
Name: hyst_cmp_array

Overview:
Multi-channel, parametrised successor to the two-sensor heat comparator. Each channel compares a pair of unsigned temperature readings (A, B) against a runtime hysteresis threshold. A channel's output only changes after its crossing condition has held for DWELL consecutive cycles. Sits between the sensor sampling front-end and the fan/heater control logic, and also produces per-channel change pulses and an aggregate flag.

Parameters:
W, 8, width of each temperature reading and of the threshold
N_CH, 4, number of independent comparator channels
DWELL, 4, consecutive qualifying cycles required before an output toggles (legal range 1..255)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en  input  1  global enable; when 0, all state, counters and outputs freeze
th  input  W  hysteresis threshold (unsigned), sampled every cycle
ts_a  input  N_CH*W  channel i reading A at bits [i*W +: W]
ts_b  input  N_CH*W  channel i reading B at bits [i*W +: W]
out  output  N_CH  1 = channel is in "A hotter than B" regime
chg  output  N_CH  one-cycle pulse when out[i] toggles
any_out  output  1  registered OR of out

Behaviour:
- Per-channel definitions (combinational):
  - valid = (a != 0) && (b != 0); a zero reading means the sensor is absent.
  - up = valid && (a > b + th).
  - dn = valid && (b > a + th).
  - All sums use W+1 bits, so no wrap-around. Comparisons are strict.
- Per-channel FSM, 4 states, plus dwell counter cnt of width clog2(DWELL+1):
  - B_GE: if up: go to A_GT when DWELL==1, else go to ARM_UP with cnt=1. Otherwise stay.
  - ARM_UP: if up: cnt+1; go to A_GT when cnt+1==DWELL. If !up (including invalid): go to B_GE, cnt=0.
  - A_GT: if dn: go to B_GE when DWELL==1, else go to ARM_DN with cnt=1. Otherwise stay. An invalid reading holds the state.
  - ARM_DN: if dn: cnt+1; go to B_GE when cnt+1==DWELL. If !dn: go to A_GT, cnt=0.
- Outputs:
  - out[i] is registered, high in A_GT or ARM_DN (no glitch during arming).
  - Latency: out rises on the DWELL-th consecutive rising edge at which up was sampled true.
  - chg[i] is registered and asserts in the same cycle out[i] changes, for exactly one cycle.
  - any_out is registered in the same cycle as out, computed from the next-state value.
- en=0: no state, counter or output changes; chg=0. Resuming continues from the frozen cnt.
- th changed mid-arming: the new th applies from that cycle; no counter reset unless the condition fails.
- Reset: all channels go to B_GE, cnt=0, out=0, chg=0, any_out=0, next cycle. Reset overrides en and aborts any arming.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

Decomposition:
- Package hyst_cmp_pkg: state enum {B_GE, ARM_UP, A_GT, ARM_DN}, function computing the counter width from DWELL, default W/N_CH/DWELL constants.
- Sub-module hyst_cmp_ch: one-channel FSM, counter, out, chg. The top level is a generate loop plus the any_out register.

Test Plan:
- Reset: hold rst 2 cycles with ch0 a=50 b=30 -> out=0, chg=0, any_out=0 throughout reset; rise occurs 4 edges after rst deasserts.
- Rise with dwell: th=10, DWELL=4, ch0 a=50 b=30 steady -> out[0]=1 after the 4th edge; chg[0]=1 for that single cycle; any_out=1 in the same cycle; other channels stay 0.
- Strict boundary and wrap: ch1 a=40 b=30 -> never rises; ch2 a=5 b=250 -> never rises; ch3 a=250 b=5 -> rises after 4 edges.
- Glitch rejection: ch0 up true 3 cycles, then a=35 b=30 for 1 cycle, then a=50 again -> out stays 0 for those 4 cycles; rises only after 4 further qualifying edges.
- Fall and invalid hold: ch0 in A_GT; set b=0 for 10 cycles -> out[0] holds 1; then a=20 b=40 -> falls after the 4th edge with chg pulse; a=20 b=30 (diff exactly 10) -> no fall.
- Freeze and mid-arm reset: en=0 after 2 qualifying edges for 5 cycles, then en=1 -> out rises after 2 more edges; separately, assert rst at cnt=3 -> channel returns to B_GE and needs 4 fresh qualifying edges.
